// File: rtl/regfile_write_router.sv
// Write-side front end for the dual-port register file: steers one request
// stream into per-bank FIFOs that drain independently onto two write ports.
module regfile_write_router #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  input  logic              stall,
  output logic              wr_en_1,
  output logic [2:0]        wr_addr_1,
  output logic [DATA_W-1:0] data_in_1,
  output logic              wr_en_2,
  output logic [2:0]        wr_addr_2,
  output logic [DATA_W-1:0] data_in_2,
  output logic [LVL_W-1:0]  level_lo,
  output logic [LVL_W-1:0]  level_hi,
  output logic              idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 3 + DATA_W;

  typedef logic [EW-1:0] entry_t;

  entry_t              mem_q   [2][DEPTH];
  logic [PW-1:0]       wp_q    [2];
  logic [PW-1:0]       wp_d    [2];
  logic [PW-1:0]       rp_q    [2];
  logic [PW-1:0]       rp_d    [2];
  logic [LVL_W-1:0]    lvl_q   [2];
  logic [LVL_W-1:0]    lvl_d   [2];
  logic                wen_q   [2];
  logic [2:0]          waddr_q [2];
  logic [DATA_W-1:0]   wdata_q [2];

  logic       sel;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;

  always_comb begin
    sel = req_addr[3];
    for (int b = 0; b < 2; b++) begin
      full[b]  = (lvl_q[b] == LVL_W'(DEPTH));
      pop[b]   = !stall && (lvl_q[b] != '0);
      push[b]  = req_valid && !full[b] && (sel == 1'(b));
      wp_d[b]  = push[b] ? wp_q[b] + PW'(1) : wp_q[b];
      rp_d[b]  = pop[b]  ? rp_q[b] + PW'(1) : rp_q[b];
      lvl_d[b] = lvl_q[b] + LVL_W'(push[b]) - LVL_W'(pop[b]);
    end
    req_ready = !full[sel];
  end

  // Storage needs no reset; only pointers and levels define validity.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst && push[b]) begin
        mem_q[b][wp_q[b]] <= {req_addr[2:0], req_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        wp_q[b]    <= '0;
        rp_q[b]    <= '0;
        lvl_q[b]   <= '0;
        wen_q[b]   <= 1'b0;
        waddr_q[b] <= '0;
        wdata_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        wp_q[b]  <= wp_d[b];
        rp_q[b]  <= rp_d[b];
        lvl_q[b] <= lvl_d[b];
        wen_q[b] <= pop[b];
        if (pop[b]) begin
          {waddr_q[b], wdata_q[b]} <= mem_q[b][rp_q[b]];
        end
      end
    end
  end

  assign wr_en_1   = wen_q[0];
  assign wr_addr_1 = waddr_q[0];
  assign data_in_1 = wdata_q[0];
  assign wr_en_2   = wen_q[1];
  assign wr_addr_2 = waddr_q[1];
  assign data_in_2 = wdata_q[1];
  assign level_lo  = lvl_q[0];
  assign level_hi  = lvl_q[1];
  assign idle      = (lvl_q[0] == '0) && (lvl_q[1] == '0)
                   && !wen_q[0] && !wen_q[1];

endmodule
